// File: rtl/mig_app_responder.sv
`timescale 1ns/1ps
// Stand-in for the MIG UI app interface. Write beats go to on-chip RAM through
// a 4-deep write-data FIFO, and reads come back in order after a fixed latency.
module mig_app_responder #(
   parameter int MEM_DATA_BITS  = 256,
   parameter int ADDR_WIDTH     = 30,
   parameter int MEM_DEPTH_LOG2 = 10,
   parameter int RD_LATENCY     = 6,
   parameter int INIT_CYCLES    = 64,
   parameter bit RDY_THROTTLE   = 1'b0
) (
   input  logic                       ddr_clk_i,
   input  logic                       ddr_rst_n_i,
   output logic                       local_init_done_o,
   input  logic [ADDR_WIDTH-1:0]      app_addr,
   input  logic [2:0]                 app_cmd,
   input  logic                       app_en,
   output logic                       app_rdy,
   input  logic [MEM_DATA_BITS-1:0]   app_wdf_data,
   input  logic                       app_wdf_wren,
   input  logic                       app_wdf_end,
   input  logic [MEM_DATA_BITS/8-1:0] app_wdf_mask,
   output logic                       app_wdf_rdy,
   output logic [MEM_DATA_BITS-1:0]   app_rd_data,
   output logic                       app_rd_data_valid,
   output logic                       app_rd_data_end,
   input  logic                       app_ref_req,
   input  logic                       app_zq_req,
   output logic                       app_ref_ack,
   output logic                       app_zq_ack,
   output logic                       app_sr_active,
   output logic [1:0]                 err_o
);

   localparam int MASK_W = MEM_DATA_BITS / 8;
   localparam int DEPTH  = 1 << MEM_DEPTH_LOG2;
   localparam int IDX_HI = MEM_DEPTH_LOG2 + 2;
   localparam int INIT_W = $clog2(INIT_CYCLES + 1);
   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
   localparam logic [2:0] CMD_WR = 3'b000;
   localparam logic [2:0] CMD_RD = 3'b001;

   typedef enum logic {WR_IDLE, WR_PEND} wr_state_t;

   logic [INIT_W-1:0]         init_cnt;
   logic                      init_done;
   logic [1:0]                thr_cnt;
   logic                      throttle;
   wr_state_t                 wr_state, wr_state_nxt;
   logic                      pend_wr;
   logic                      pend_set;
   logic [MEM_DEPTH_LOG2-1:0] pend_idx;
   logic [MEM_DEPTH_LOG2-1:0] cmd_idx;

   logic [MEM_DATA_BITS-1:0]  fifo_data [4];
   logic [MASK_W-1:0]         fifo_mask [4];
   logic [1:0]                fifo_wp, fifo_rp;
   logic [2:0]                fifo_cnt;
   logic                      fifo_empty;
   logic                      fifo_push, fifo_pop;

   logic                      cmd_acc, wr_cmd, rd_cmd, bad_cmd, beat_acc;
   logic                      ram_we;
   logic [MEM_DEPTH_LOG2-1:0] ram_widx;
   logic [MEM_DATA_BITS-1:0]  ram_wdata;
   logic [MASK_W-1:0]         ram_wmask;
   logic [MEM_DATA_BITS-1:0]  mem [DEPTH];

   logic [RD_LATENCY-1:0]     vld_p;
   logic [MEM_DATA_BITS-1:0]  dat_p [RD_LATENCY];

   logic [1:0]                mnt_req;
   logic [1:0]                mnt_cnt [2];
   logic [1:0]                mnt_ack;
   logic [1:0]                err_q;

   // Address bits outside the word index are deliberately ignored (aliasing).
   generate
      if (ADDR_WIDTH > IDX_HI + 1) begin : g_alias
         logic unused_addr_bits;
         assign unused_addr_bits = ^{app_addr[ADDR_WIDTH-1:IDX_HI+1], app_addr[2:0]};
      end else begin : g_noalias
         logic unused_addr_bits;
         assign unused_addr_bits = ^app_addr[2:0];
      end
   endgenerate

   assign cmd_idx    = app_addr[IDX_HI:3];
   assign throttle   = RDY_THROTTLE && (thr_cnt == 2'd3);
   assign pend_wr    = (wr_state == WR_PEND);
   assign fifo_empty = (fifo_cnt == 3'd0);

   assign app_rdy     = init_done & ~throttle & ~pend_wr;
   assign app_wdf_rdy = init_done & (fifo_cnt < 3'd4);
   assign cmd_acc     = app_en & app_rdy;
   assign wr_cmd      = cmd_acc & (app_cmd == CMD_WR);
   assign rd_cmd      = cmd_acc & (app_cmd == CMD_RD);
   assign bad_cmd     = cmd_acc & (app_cmd != CMD_WR) & (app_cmd != CMD_RD);
   assign beat_acc    = app_wdf_wren & app_wdf_rdy;

   always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
      if (!ddr_rst_n_i) begin
         init_cnt  <= '0;
         init_done <= 1'b0;
         thr_cnt   <= 2'd0;
      end else begin
         thr_cnt <= thr_cnt + 2'd1;
         if (!init_done) begin
            init_cnt <= init_cnt + INIT_W'(1);
            if (init_cnt == INIT_LAST)
               init_done <= 1'b1;
         end
      end
   end

   always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
      if (!ddr_rst_n_i)
         wr_state <= WR_IDLE;
      else
         wr_state <= wr_state_nxt;
   end

   // Routes write data to the RAM: FIFO head first, else the same-cycle beat.
   always_comb begin
      wr_state_nxt = wr_state;
      ram_we       = 1'b0;
      ram_widx     = cmd_idx;
      ram_wdata    = app_wdf_data;
      ram_wmask    = app_wdf_mask;
      fifo_push    = 1'b0;
      fifo_pop     = 1'b0;
      pend_set     = 1'b0;
      case (wr_state)
         WR_IDLE: begin
            if (wr_cmd && !fifo_empty) begin
               ram_we    = 1'b1;
               ram_wdata = fifo_data[fifo_rp];
               ram_wmask = fifo_mask[fifo_rp];
               fifo_pop  = 1'b1;
               fifo_push = beat_acc;
            end else if (wr_cmd && beat_acc) begin
               ram_we = 1'b1;
            end else if (wr_cmd) begin
               pend_set     = 1'b1;
               wr_state_nxt = WR_PEND;
            end else begin
               fifo_push = beat_acc;
            end
         end
         WR_PEND: begin
            ram_widx = pend_idx;
            if (beat_acc) begin
               ram_we       = 1'b1;
               wr_state_nxt = WR_IDLE;
            end
         end
         default: wr_state_nxt = WR_IDLE;
      endcase
   end

   always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
      if (!ddr_rst_n_i) begin
         fifo_wp  <= 2'd0;
         fifo_rp  <= 2'd0;
         fifo_cnt <= 3'd0;
      end else begin
         if (fifo_push)
            fifo_wp <= fifo_wp + 2'd1;
         if (fifo_pop)
            fifo_rp <= fifo_rp + 2'd1;
         fifo_cnt <= fifo_cnt + 3'(fifo_push) - 3'(fifo_pop);
      end
   end

   always_ff @(posedge ddr_clk_i) begin
      if (fifo_push) begin
         fifo_data[fifo_wp] <= app_wdf_data;
         fifo_mask[fifo_wp] <= app_wdf_mask;
      end
      if (pend_set)
         pend_idx <= cmd_idx;
   end

   // A set mask bit protects that byte from being written.
   always_ff @(posedge ddr_clk_i) begin
      if (ram_we) begin
         for (int b = 0; b < MASK_W; b++) begin
            if (!ram_wmask[b])
               mem[ram_widx][b*8 +: 8] <= ram_wdata[b*8 +: 8];
         end
      end
   end

   // Stage p0 is the synchronous RAM read; p1..p(N-1) form the latency delay line.
   always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
      if (!ddr_rst_n_i)
         vld_p <= '0;
      else
         vld_p <= {vld_p[RD_LATENCY-2:0], rd_cmd};
   end

   always_ff @(posedge ddr_clk_i) begin
      if (rd_cmd)
         dat_p[0] <= mem[cmd_idx];
      for (int s = 1; s < RD_LATENCY; s++)
         dat_p[s] <= dat_p[s-1];
   end

   assign app_rd_data_valid = vld_p[RD_LATENCY-1];
   assign app_rd_data_end   = vld_p[RD_LATENCY-1];
   assign app_rd_data       = vld_p[RD_LATENCY-1] ? dat_p[RD_LATENCY-1] : '0;

   // Counter value 0 is idle; 1..3 run, and the ack fires as it wraps back to 0.
   assign mnt_req = {app_zq_req, app_ref_req};

   always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
      if (!ddr_rst_n_i) begin
         for (int m = 0; m < 2; m++)
            mnt_cnt[m] <= 2'd0;
         mnt_ack <= 2'b00;
      end else begin
         for (int m = 0; m < 2; m++) begin
            mnt_ack[m] <= (mnt_cnt[m] == 2'd3);
            if (mnt_cnt[m] != 2'd0)
               mnt_cnt[m] <= mnt_cnt[m] + 2'd1;
            else if (mnt_req[m])
               mnt_cnt[m] <= 2'd1;
         end
      end
   end

   always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
      if (!ddr_rst_n_i) begin
         err_q <= 2'b00;
      end else begin
         if (bad_cmd)
            err_q[0] <= 1'b1;
         if (app_wdf_wren && !app_wdf_end)
            err_q[1] <= 1'b1;
      end
   end

   assign local_init_done_o = init_done;
   assign app_ref_ack       = mnt_ack[0];
   assign app_zq_ack        = mnt_ack[1];
   assign app_sr_active     = 1'b0;
   assign err_o             = err_q;

endmodule

// File: tb/tb_mig_app_responder.sv
`timescale 1ns/1ps
// Directed bench for mig_app_responder: a vector table for the basic write/read
// path plus hand-written sequences for stalls, FIFO fill, throttle and reset.
module tb_mig_app_responder;

   localparam int DW = 256;
   localparam int AW = 30;
   localparam int MW = 32;

   typedef struct packed {
      logic          en;
      logic [2:0]    cmd;
      logic [AW-1:0] addr;
      logic          wren;
      logic [DW-1:0] wdata;
      logic [MW-1:0] wmask;
      logic          exp_vld;
      logic [DW-1:0] exp_data;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          en, wren, wend, ref_req, zq_req;
   logic [2:0]    cmd;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [MW-1:0] wmask;
   logic          done, rdy, wrdy, vld, vend, ref_ack, zq_ack, sr;
   logic [DW-1:0] rdata;
   logic [1:0]    err;

   logic          en_t, wren_t, wend_t, ref_t, zq_t;
   logic [2:0]    cmd_t;
   logic [AW-1:0] addr_t;
   logic [DW-1:0] wdata_t;
   logic [MW-1:0] wmask_t;
   logic          done_t, rdy_t, wrdy_t, vld_t, vend_t, ref_ack_t, zq_ack_t, sr_t;
   logic [DW-1:0] rdata_t;
   logic [1:0]    err_t;

   int n_cmp = 0;
   int n_bad = 0;
   vec_t tbl [27];

   mig_app_responder dut (
      .ddr_clk_i(clk), .ddr_rst_n_i(rst_n), .local_init_done_o(done),
      .app_addr(addr), .app_cmd(cmd), .app_en(en), .app_rdy(rdy),
      .app_wdf_data(wdata), .app_wdf_wren(wren), .app_wdf_end(wend),
      .app_wdf_mask(wmask), .app_wdf_rdy(wrdy),
      .app_rd_data(rdata), .app_rd_data_valid(vld), .app_rd_data_end(vend),
      .app_ref_req(ref_req), .app_zq_req(zq_req), .app_ref_ack(ref_ack),
      .app_zq_ack(zq_ack), .app_sr_active(sr), .err_o(err)
   );

   mig_app_responder #(.RDY_THROTTLE(1'b1)) dut_t (
      .ddr_clk_i(clk), .ddr_rst_n_i(rst_n), .local_init_done_o(done_t),
      .app_addr(addr_t), .app_cmd(cmd_t), .app_en(en_t), .app_rdy(rdy_t),
      .app_wdf_data(wdata_t), .app_wdf_wren(wren_t), .app_wdf_end(wend_t),
      .app_wdf_mask(wmask_t), .app_wdf_rdy(wrdy_t),
      .app_rd_data(rdata_t), .app_rd_data_valid(vld_t), .app_rd_data_end(vend_t),
      .app_ref_req(ref_t), .app_zq_req(zq_t), .app_ref_ack(ref_ack_t),
      .app_zq_ack(zq_ack_t), .app_sr_active(sr_t), .err_o(err_t)
   );

   function automatic logic [DW-1:0] rep(input logic [31:0] w);
      return {8{w}};
   endfunction

   function automatic logic [DW-1:0] hpat(input int k);
      return rep(32'h5A00_0000 + 32'(k));
   endfunction

   function automatic vec_t mkv(input logic e, input logic [2:0] c, input logic [AW-1:0] a,
                                input logic w, input logic [DW-1:0] d, input logic [MW-1:0] m);
      vec_t v;
      v.en = e; v.cmd = c; v.addr = a; v.wren = w; v.wdata = d; v.wmask = m;
      v.exp_vld = 1'b0; v.exp_data = '0;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic idle();
      en = 1'b0; cmd = 3'b000; addr = '0; wren = 1'b0; wend = 1'b0;
      wdata = '0; wmask = '0; ref_req = 1'b0; zq_req = 1'b0;
   endtask

   // Issues one read in the current cycle and checks latency and returned data.
   task automatic rd_check(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
      int lat;
      chk({nm, "_rdy"}, DW'(rdy), DW'(1));
      en = 1'b1; cmd = 3'b001; addr = a;
      @(negedge clk);
      en = 1'b0; cmd = 3'b000;
      lat = 1;
      while (!vld && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, "_lat"}, DW'(lat), DW'(6));
      chk({nm, "_data"}, rdata, exp);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

   initial begin
      int bad, bad_ref, bad_zq, k, cyc, issued, got, lows;
      logic hist [64];

      for (int i = 0; i < 8; i++)
         tbl[i] = mkv(1'b1, 3'b000, AW'(i * 8), 1'b1, DW'(i), '0);
      tbl[8] = mkv(1'b1, 3'b000, AW'('h48), 1'b1, rep(32'h1111_1111), '0);
      tbl[9] = mkv(1'b1, 3'b000, AW'('h204D), 1'b1, rep(32'hAAAA_AAAA), 32'hFFFF_FFFE);
      for (int i = 0; i < 8; i++)
         tbl[10+i] = mkv(1'b1, 3'b001, AW'(i * 8), 1'b0, '0, '0);
      tbl[18] = mkv(1'b1, 3'b001, AW'('h48), 1'b0, '0, '0);
      for (int i = 19; i < 27; i++)
         tbl[i] = mkv(1'b0, 3'b000, '0, 1'b0, '0, '0);
      for (int i = 0; i < 8; i++) begin
         tbl[16+i].exp_vld  = 1'b1;
         tbl[16+i].exp_data = DW'(i);
      end
      tbl[24].exp_vld  = 1'b1;
      tbl[24].exp_data = {{7{32'h1111_1111}}, 32'h1111_11AA};

      rst_n = 1'b0;
      idle();
      en_t = 1'b0; cmd_t = 3'b000; addr_t = '0; wren_t = 1'b0; wend_t = 1'b0;
      wdata_t = '0; wmask_t = '0; ref_t = 1'b0; zq_t = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_outs", DW'({done, rdy, wrdy, vld, vend, ref_ack, zq_ack, sr, err}), '0);
      chk("rst_outs_t", DW'({done_t, rdy_t, wrdy_t, vld_t, vend_t, ref_ack_t, zq_ack_t, sr_t, err_t}), '0);
      chk("rst_rdata", rdata, '0);
      rst_n = 1'b1;

      // Init: low through the 63rd clock, high on the 64th.
      bad = 0;
      for (int i = 1; i <= 63; i++) begin
         @(negedge clk);
         if (done || rdy || wrdy || done_t) bad++;
      end
      chk("init_low_1_63", DW'(bad), '0);
      @(negedge clk);
      chk("init_high_64", DW'({done, rdy, wrdy}), DW'(3'b111));

      // Table: 8 writes, aliased masked write, 9 reads, drain.
      for (int i = 0; i < 27; i++) begin
         chk($sformatf("t2_vld[%0d]", i), DW'({vld, vend}), DW'({2{tbl[i].exp_vld}}));
         chk($sformatf("t2_data[%0d]", i), rdata, tbl[i].exp_data);
         chk($sformatf("t2_rdy[%0d]", i), DW'({rdy, wrdy}), DW'(2'b11));
         en = tbl[i].en; cmd = tbl[i].cmd; addr = tbl[i].addr;
         wren = tbl[i].wren; wend = tbl[i].wren; wdata = tbl[i].wdata; wmask = tbl[i].wmask;
         @(negedge clk);
      end
      idle();
      chk("t2_err", DW'(err), '0);

      // Write command whose data arrives three cycles later.
      chk("t3_rdy_pre", DW'(rdy), DW'(1));
      en = 1'b1; cmd = 3'b000; addr = AW'('h40);
      @(negedge clk);
      idle();
      for (int j = 1; j <= 3; j++) begin
         chk($sformatf("t3_rdy_low[%0d]", j), DW'(rdy), '0);
         chk($sformatf("t3_wrdy[%0d]", j), DW'(wrdy), DW'(1));
         if (j == 3) begin
            wren = 1'b1; wend = 1'b1; wdata = rep(32'hDEAD_BEEF);
         end
         @(negedge clk);
      end
      idle();
      chk("t3_rdy_back", DW'(rdy), DW'(1));
      rd_check(AW'('h40), rep(32'hDEAD_BEEF), "t3_rd");

      // FIFO fill with no command, dropped fifth beat, then drain in order.
      for (int j = 0; j < 5; j++) begin
         chk($sformatf("t4_wrdy_fill[%0d]", j), DW'(wrdy), DW'(j < 4));
         wren = 1'b1; wend = 1'b1;
         wdata = (j < 4) ? rep(32'hC0DE_0000 + 32'(j)) : rep(32'h0BAD_0BAD);
         @(negedge clk);
      end
      idle();
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("t4_wrdy_drain[%0d]", j), DW'(wrdy), DW'(j > 0));
         chk($sformatf("t4_rdy_drain[%0d]", j), DW'(rdy), DW'(1));
         en = 1'b1; cmd = 3'b000; addr = AW'('h100 + j * 8);
         @(negedge clk);
      end
      idle();
      en = 1'b1; cmd = 3'b000; addr = AW'('h200);
      wren = 1'b1; wend = 1'b1; wdata = rep(32'hF00D_0200);
      @(negedge clk);
      idle();
      for (int j = 0; j < 4; j++)
         rd_check(AW'('h100 + j * 8), rep(32'hC0DE_0000 + 32'(j)), $sformatf("t4_rd%0d", j));
      rd_check(AW'('h200), rep(32'hF00D_0200), "t4_bypass");

      // Beat without end: flagged but still stored.
      en = 1'b1; cmd = 3'b000; addr = AW'('h208);
      wren = 1'b1; wend = 1'b0; wdata = rep(32'h600D_0208);
      @(negedge clk);
      idle();
      chk("err1_set", DW'(err), DW'(2'b10));
      rd_check(AW'('h208), rep(32'h600D_0208), "err1_rd");

      // Maintenance: ref at 0, 2 (ignored), 6; zq at 1.
      bad_ref = 0; bad_zq = 0;
      for (int j = 0; j < 12; j++) begin
         if (ref_ack !== (j == 4 || j == 10)) bad_ref++;
         if (zq_ack !== (j == 5)) bad_zq++;
         ref_req = (j == 0 || j == 2 || j == 6);
         zq_req  = (j == 1);
         @(negedge clk);
      end
      idle();
      chk("mnt_ref_ack", DW'(bad_ref), '0);
      chk("mnt_zq_ack", DW'(bad_zq), '0);

      // Throttled instance: 16 writes, then 16 reads with app_en held high.
      k = 0; cyc = 0;
      while (k < 16 && cyc < 100) begin
         if (rdy_t) begin
            en_t = 1'b1; cmd_t = 3'b000; addr_t = AW'(k * 8);
            wren_t = 1'b1; wend_t = 1'b1; wdata_t = hpat(k);
            k++;
         end else begin
            en_t = 1'b0; wren_t = 1'b0; wend_t = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      en_t = 1'b0; wren_t = 1'b0; wend_t = 1'b0;
      chk("t5_wr_issued", DW'(k), DW'(16));
      issued = 0; got = 0; cyc = 0;
      while (got < 16 && cyc < 100) begin
         if (vld_t) begin
            chk($sformatf("t5_data[%0d]", got), rdata_t, hpat(got));
            got++;
         end
         hist[cyc] = rdy_t;
         if (issued < 16) begin
            en_t = 1'b1; cmd_t = 3'b001; addr_t = AW'(issued * 8);
            if (rdy_t) issued++;
         end else begin
            en_t = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      en_t = 1'b0;
      chk("t5_beats", DW'(got), DW'(16));
      lows = 0;
      for (int i = 0; i < 4; i++)
         if (!hist[i]) lows++;
      chk("t5_one_low_per_4", DW'(lows), DW'(1));
      bad = 0;
      for (int i = 4; i < 20; i++)
         if (hist[i] !== hist[i-4]) bad++;
      chk("t5_rdy_period", DW'(bad), '0);
      chk("t5_err", DW'(err_t), '0);

      // Reset with three reads in flight.
      for (int j = 0; j < 3; j++) begin
         en = 1'b1; cmd = 3'b001; addr = AW'(j * 8);
         @(negedge clk);
      end
      idle();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_outs", DW'({done, rdy, wrdy, vld, err}), '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (vld) bad++;
      end
      chk("t6_no_vld", DW'(bad), '0);
      chk("t6_done", DW'(done), DW'(1));
      rd_check(AW'('h40), rep(32'hDEAD_BEEF), "t6_ram_kept");

      // Illegal command: accepted, flagged, no response.
      chk("t6_ill_rdy", DW'(rdy), DW'(1));
      en = 1'b1; cmd = 3'b010; addr = '0;
      @(negedge clk);
      idle();
      chk("t6_err0", DW'(err), DW'(2'b01));
      chk("t6_ill_rdy_after", DW'(rdy), DW'(1));
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         if (vld) bad++;
         @(negedge clk);
      end
      chk("t6_ill_no_vld", DW'(bad), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
